// File: rtl/launcher_pkg.sv
// Shared types and widths for the program launcher and its cycle timers.
package launcher_pkg;

    localparam int CNT_W = 16;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/prog_launcher_run_timer.sv
// Saturating cycle counter with synchronous clear; flags the cycle whose count+1 reaches LIMIT.
module run_timer
    import launcher_pkg::*;
#(
    parameter logic [CNT_W-1:0] LIMIT = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Widened compare so a saturated count can never wrap onto LIMIT.
    assign hit_o = (({1'b0, cnt_q} + 17'd1) == {1'b0, LIMIT});
    assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_launcher.sv
// Host-side Start/Ack sequencer: runs NUM_PROGS programs per Go and reports per-program cycle counts.
module prog_launcher
    import launcher_pkg::*;
#(
    parameter int unsigned NUM_PROGS    = 3,
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 16'hFFFF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             Ack,
    output logic             Start,
    output logic [IDX_W-1:0] ProgIdx,
    output logic             Busy,
    output logic             Done,
    output logic             TimedOut,
    output logic [CNT_W-1:0] CycleCnt,
    output logic             CntValid
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cv_q, cv_d;
    logic             to_q, to_d;

    logic [CNT_W-1:0] hold_cnt;
    logic             hold_hit;
    logic [CNT_W-1:0] run_cnt;
    logic             run_hit;

    run_timer #(.LIMIT(CNT_W'(START_CYCLES))) u_hold (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (state_q != S_START),
        .en_i  (state_q == S_START),
        .cnt_o (hold_cnt),
        .hit_o (hold_hit)
    );

    run_timer #(.LIMIT(CNT_W'(TIMEOUT))) u_run (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (state_q != S_RUN),
        .en_i  (state_q == S_RUN),
        .cnt_o (run_cnt),
        .hit_o (run_hit)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cv_d    = 1'b0;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    state_d = S_START;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (hold_hit) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Ack takes priority over a coincident timeout.
                if (Ack) begin
                    cnt_d = run_cnt + CNT_W'(1);
                    cv_d  = 1'b1;
                    if (idx_q == IDX_W'(NUM_PROGS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_START;
                    end
                end else if (run_hit) begin
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (Go) begin
                    to_d    = 1'b0;
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            cv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cv_q    <= cv_d;
            to_q    <= to_d;
        end
    end

    assign Start    = (state_q == S_START);
    assign Busy     = (state_q == S_START) || (state_q == S_RUN);
    assign Done     = (state_q == S_DONE);
    assign TimedOut = to_q;
    assign ProgIdx  = idx_q;
    assign CycleCnt = cnt_q;
    assign CntValid = cv_q;

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher: default instance for sequencing, TIMEOUT=20 instance for abort cases.
module tb_prog_launcher;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Go = 1'b0, Ack = 1'b0;
    logic        go2 = 1'b0, ack2 = 1'b0;

    logic        Start, Busy, Done, TimedOut, CntValid;
    logic [1:0]  ProgIdx;
    logic [15:0] CycleCnt;
    logic        start2, busy2, done2, to2, cv2;
    logic [1:0]  idx2;
    logic [15:0] cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    prog_launcher dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .Ack(Ack),
        .Start(Start), .ProgIdx(ProgIdx), .Busy(Busy), .Done(Done),
        .TimedOut(TimedOut), .CycleCnt(CycleCnt), .CntValid(CntValid)
    );

    prog_launcher #(.NUM_PROGS(3), .START_CYCLES(2), .TIMEOUT(20)) dut_to (
        .Clk(Clk), .Reset(Reset), .Go(go2), .Ack(ack2),
        .Start(start2), .ProgIdx(idx2), .Busy(busy2), .Done(done2),
        .TimedOut(to2), .CycleCnt(cnt2), .CntValid(cv2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered at the first START cycle of a program; leaves at the cycle after Ack.
    task automatic run_prog(input int k, input int idx, input bit last,
                            input bit keep_ack, input bit glitch);
        int w = 0;
        check("busy_start", 32'(Busy), 1);
        check("idx_start", 32'(ProgIdx), idx);
        while (Start === 1'b1 && w < 8) begin
            Go = glitch && (w == 0);
            w++;
            @(negedge Clk);
        end
        Go = 1'b0;
        check("start_width", w, 2);
        check("cv_low_run", 32'(CntValid), 0);
        check("busy_run", 32'(Busy), 1);
        if (k > 1) begin
            Ack = 1'b0;
            Go  = glitch;
            @(negedge Clk);
            Go  = 1'b0;
            repeat (k - 2) @(negedge Clk);
        end
        Ack = 1'b1;
        @(negedge Clk);
        if (!keep_ack) Ack = 1'b0;
        check("cycle_cnt", 32'(CycleCnt), k);
        check("cnt_valid", 32'(CntValid), 1);
        if (last) begin
            check("done", 32'(Done), 1);
            check("start_off", 32'(Start), 0);
            check("timed_out", 32'(TimedOut), 0);
            check("idx_last", 32'(ProgIdx), idx);
        end else begin
            check("next_start", 32'(Start), 1);
            check("next_idx", 32'(ProgIdx), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit saw_cv;

        @(negedge Clk);
        check("rst_start", 32'(Start), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_to", 32'(TimedOut), 0);
        check("rst_idx", 32'(ProgIdx), 0);
        check("rst_cnt", 32'(CycleCnt), 0);
        check("rst_cv", 32'(CntValid), 0);
        Reset = 1'b0;

        // Ack after 5, 7, 9 RUN cycles.
        @(negedge Clk); Go = 1'b1;
        @(negedge Clk); Go = 1'b0;
        run_prog(5, 0, 0, 0, 0);
        run_prog(7, 1, 0, 0, 0);
        run_prog(9, 2, 1, 0, 0);
        @(negedge Clk);
        check("done_hold", 32'(Done), 1);
        check("cnt_retained", 32'(CycleCnt), 9);
        check("cv_single", 32'(CntValid), 0);

        // Go in DONE restarts next cycle; Go pulses in START/RUN are ignored.
        Go = 1'b1;
        @(negedge Clk); Go = 1'b0;
        check("restart_done", 32'(Done), 0);
        check("restart_start", 32'(Start), 1);
        run_prog(4, 0, 0, 0, 1);
        run_prog(6, 1, 0, 0, 1);
        run_prog(3, 2, 1, 0, 1);

        // Ack still high while Start is reasserted.
        @(negedge Clk); Go = 1'b1;
        @(negedge Clk); Go = 1'b0;
        run_prog(1, 0, 0, 1, 0);
        run_prog(1, 1, 0, 1, 0);
        run_prog(1, 2, 1, 0, 0);

        // TIMEOUT=20 with no Ack.
        @(negedge Clk); go2 = 1'b1;
        @(negedge Clk); go2 = 1'b0;
        w = 0;
        while (start2 === 1'b1 && w < 8) begin w++; @(negedge Clk); end
        check("to_start_width", w, 2);
        saw_cv = 1'b0;
        repeat (19) begin
            if (cv2) saw_cv = 1'b1;
            @(negedge Clk);
        end
        check("to_busy_c20", 32'(busy2), 1);
        check("to_done_c20", 32'(done2), 0);
        if (cv2) saw_cv = 1'b1;
        @(negedge Clk);
        check("to_done", 32'(done2), 1);
        check("to_flag", 32'(to2), 1);
        check("to_idx", 32'(idx2), 0);
        check("to_no_cv", 32'(saw_cv | cv2), 0);

        // Ack exactly on RUN cycle 20 beats the timeout.
        go2 = 1'b1;
        @(negedge Clk); go2 = 1'b0;
        check("to_clear", 32'(to2), 0);
        repeat (2) @(negedge Clk);
        repeat (19) @(negedge Clk);
        ack2 = 1'b1;
        @(negedge Clk); ack2 = 1'b0;
        check("edge_cnt", 32'(cnt2), 20);
        check("edge_cv", 32'(cv2), 1);
        check("edge_to", 32'(to2), 0);
        check("edge_idx", 32'(idx2), 1);
        check("edge_start", 32'(start2), 1);

        // Asynchronous reset in the middle of RUN.
        @(negedge Clk); Go = 1'b1;
        @(negedge Clk); Go = 1'b0;
        run_prog(2, 0, 0, 0, 0);
        repeat (4) @(negedge Clk);
        check("pre_rst_busy", 32'(Busy), 1);
        #2 Reset = 1'b1;
        #1;
        check("arst_start", 32'(Start), 0);
        check("arst_busy", 32'(Busy), 0);
        check("arst_idx", 32'(ProgIdx), 0);
        check("arst_cnt", 32'(CycleCnt), 0);
        check("arst_done", 32'(Done), 0);
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk); Go = 1'b1;
        @(negedge Clk); Go = 1'b0;
        run_prog(3, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
